// File: rtl/reg_file_array_if.sv
// reg_file_array_if: read/write bus of the architectural register file.
// The master side (core datapath) drives the two read addresses and the
// single write port. The slave side (register file) returns both operands
// and the committed-write counter.
interface reg_file_array_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] READ_Addr_1;
    logic [ADDR_WIDTH-1:0] READ_Addr_2;
    logic                  WRITE_En;
    logic [ADDR_WIDTH-1:0] WRITE_Addr;
    logic [DATA_WIDTH-1:0] WRITE_Data;
    logic [DATA_WIDTH-1:0] READ_Data_1;
    logic [DATA_WIDTH-1:0] READ_Data_2;
    logic [15:0]           WRITE_Count;

    modport master (
        output READ_Addr_1,
        output READ_Addr_2,
        output WRITE_En,
        output WRITE_Addr,
        output WRITE_Data,
        input  READ_Data_1,
        input  READ_Data_2,
        input  WRITE_Count
    );

    modport slave (
        input  READ_Addr_1,
        input  READ_Addr_2,
        input  WRITE_En,
        input  WRITE_Addr,
        input  WRITE_Data,
        output READ_Data_1,
        output READ_Data_2,
        output WRITE_Count
    );
endinterface

// File: rtl/reg_file_array.sv
// reg_file_array: architectural integer register file of the single-cycle core.
// Two combinational read ports, one synchronous write port, x0 hardwired to zero.
// x2 (stack pointer) resets to SP_INIT, every other register resets to zero.
// WRITE_Count counts committed writes to non-zero registers and wraps silently.
// Optional build macro: REG_FILE_BYPASS_EN -- when defined, a write in flight
// to the address being read is forwarded to that read port in the same cycle.
module reg_file_array #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = '0
) (
    input  logic            CLK,
    input  logic            RSTN,
    reg_file_array_if.slave bus
);

    localparam int unsigned           NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

    // Flattened view of all registers; entry 0 is a constant zero, not a flop.
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_view;
    logic                                write_commit;
    logic [15:0]                         write_count;
    logic [DATA_WIDTH-1:0]               read_data_1;
    logic [DATA_WIDTH-1:0]               read_data_2;

    // A write only takes effect when enabled and aimed at a real register;
    // a low enable masks any X on the address/data inputs.
    assign write_commit = bus.WRITE_En && (bus.WRITE_Addr != ZERO_ADDR);

    assign reg_view[0] = '0;

    // One storage word per architectural register x1..x(N-1).
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        localparam logic [DATA_WIDTH-1:0] RESET_VAL = (r == 2) ? SP_INIT : '0;
        localparam logic [ADDR_WIDTH-1:0] MY_ADDR   = ADDR_WIDTH'(r);

        logic [DATA_WIDTH-1:0] value;

        // Load the reset contents immediately on reset, otherwise capture the writeback value when addressed.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                value <= RESET_VAL;
            end else if (write_commit && (bus.WRITE_Addr == MY_ADDR)) begin
                value <= bus.WRITE_Data;
            end
        end

        assign reg_view[r] = value;
    end

    // Count committed non-zero writes; reset wins over a coincident write.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            write_count <= '0;
        end else if (write_commit) begin
            write_count <= write_count + 16'd1;
        end
    end

    // Read port 1: stored value, optionally overridden by the write in flight.
    always_comb begin
        read_data_1 = reg_view[bus.READ_Addr_1];
`ifdef REG_FILE_BYPASS_EN
        if (write_commit && (bus.WRITE_Addr == bus.READ_Addr_1)) begin
            read_data_1 = bus.WRITE_Data;
        end
`endif
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        read_data_2 = reg_view[bus.READ_Addr_2];
`ifdef REG_FILE_BYPASS_EN
        if (write_commit && (bus.WRITE_Addr == bus.READ_Addr_2)) begin
            read_data_2 = bus.WRITE_Data;
        end
`endif
    end

    assign bus.READ_Data_1 = read_data_1;
    assign bus.READ_Data_2 = read_data_2;
    assign bus.WRITE_Count = write_count;

endmodule

// File: doc/reg_file_array.md
Name: reg_file_array

Overview:
- Architectural integer register file for the single-cycle core, directly downstream of the read-address gating stage.
- Consumes the gated READ_Addr_1/READ_Addr_2 and returns two source operands combinationally.
- Accepts one write per clock from the writeback mux.
- x0 is hardwired to zero, so a disabled read (address forced to 0) always yields 0.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, address width; register count = 2**ADDR_WIDTH.
- SP_INIT, 32'h0000_0000, reset value of x2 (stack pointer); all other registers reset to 0.

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- READ_Addr_1  input  ADDR_WIDTH  read port 1 address (from the read-address gating stage).
- READ_Addr_2  input  ADDR_WIDTH  read port 2 address (from the read-address gating stage).
- WRITE_En  input  1  write enable from the control unit.
- WRITE_Addr  input  ADDR_WIDTH  destination register (rd).
- WRITE_Data  input  DATA_WIDTH  writeback value.
- READ_Data_1  output  DATA_WIDTH  operand for rs1.
- READ_Data_2  output  DATA_WIDTH  operand for rs2.
- WRITE_Count  output  16  count of committed writes to non-zero registers, for debug and coverage.

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTN is asynchronous and active-low.
- RSTN low: immediately clear x1 and x3..x(N-1) to 0, load x2 with SP_INIT, clear WRITE_Count to 0. This does not wait for a clock edge.
- Reset mid-operation: RSTN low overrides any write on the same edge; the write is lost.
- Reset release is synchronous in effect: the first write can commit on the first rising CLK edge with RSTN high.
- Storage: 2**ADDR_WIDTH − 1 flops of DATA_WIDTH each. x0 has no storage.
- Reads: combinational, zero-cycle latency. READ_Data_n = 0 when READ_Addr_n == 0, otherwise the stored value.
- Write: on rising CLK, if WRITE_En == 1 and WRITE_Addr != 0, reg[WRITE_Addr] <= WRITE_Data. The new value is visible on reads in the following cycle (default build).
- Writes to x0 are silently discarded. They do not increment WRITE_Count.
- WRITE_En == 0: no state change, regardless of WRITE_Addr/WRITE_Data (X on those inputs must not propagate).
- WRITE_Count: increments by 1 on each committed non-zero write. Wraps from 16'hFFFF to 16'h0000 with no flag.
- Reads from both ports may target the same address in the same cycle; both return the same value.
- Read/write collision (default build): reading address A while writing A returns the pre-edge old value that cycle.
- No internal FSM beyond the storage array and counter. Single write port, so write-write conflicts cannot occur.
- Outputs at reset:
  - READ_Data_n reflect the reset contents: 0, or SP_INIT when the address is 2.
  - WRITE_Count = 0.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding. If WRITE_En == 1, WRITE_Addr != 0, and WRITE_Addr == READ_Addr_n, then READ_Data_n = WRITE_Data combinationally in the same cycle. Address 0 is never bypassed (still reads 0).
- Not defined: no forwarding; a collision returns the old stored value as described above.
- Storage update timing and WRITE_Count are identical in both builds.

Test Plan:
- Reset with SP_INIT=32'h0000_8000: assert RSTN low mid-cycle with no clock edge -> all reads 0 except addr 2 reads 32'h0000_8000; WRITE_Count = 0.
- Write 32'hDEAD_BEEF to x5, then read addr 5 on both ports next cycle -> both ports 32'hDEAD_BEEF; WRITE_Count = 1.
- Write 32'h1234_5678 to x0 with WRITE_En = 1 -> READ_Data_1 at addr 0 stays 0; WRITE_Count unchanged.
- Collision: x7 holds 32'h1; same cycle write 32'h2 to x7 and read addr 7:
  - bypass build -> read returns 32'h2 in that cycle.
  - default build -> read returns 32'h1 in that cycle, 32'h2 the cycle after.
- WRITE_En = 0 with WRITE_Addr = 9 and WRITE_Data = 32'hFFFF_FFFF -> x9 unchanged; count unchanged.
- Counter and reset priority:
  - Perform 65 536 non-zero writes -> WRITE_Count wraps to 0.
  - Pull RSTN low coincident with a write to x3 -> x3 reads 0 after reset.
